// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address stack for the Reaper core.
// Optional REAPER_SINGLE_STEP_EN adds Step_Mode: every instruction waits for a button press.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                Sys_Clock,
    input  logic                Reset_Raw,
    input  logic                Halt,
    input  logic                IO_Wait,
    input  logic                DB_Button,
`ifdef REAPER_SINGLE_STEP_EN
    input  logic                Step_Mode,
`endif
    input  logic                Jump,
    input  logic                Branch,
    input  logic                ALU_True,
    input  logic                Stack_Enable,
    input  logic                Stack_Write,
    input  logic [PC_WIDTH-1:0] Jump_Addr,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] Ret_Add,
    output logic                Commit,
    output logic                Err_Out,
    output logic [1:0]          Seq_State
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                btn_q;
    logic                err_q, err_d;

    logic                commit_c;
    logic                push_c;
    logic                call_c;
    logic                ret_c;
    logic                full_c;
    logic                empty_c;
    logic                wait_req_c;
    logic                press_c;
    logic [IDX_W-1:0]    top_idx_c;
    logic [PC_WIDTH-1:0] top_c;
    logic [PC_WIDTH-1:0] pc_inc_c;

`ifdef REAPER_SINGLE_STEP_EN
    assign wait_req_c = IO_Wait | Step_Mode;
`else
    assign wait_req_c = IO_Wait;
`endif

    assign call_c    = Stack_Enable & Stack_Write;
    assign ret_c     = Stack_Enable & ~Stack_Write;
    assign full_c    = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty_c   = (cnt_q == '0);
    assign press_c   = DB_Button & ~btn_q;
    assign top_idx_c = IDX_W'(cnt_q - CNT_W'(1));
    assign top_c     = empty_c ? '0 : stack_q[top_idx_c];
    assign pc_inc_c  = pc_q + PC_WIDTH'(1);

    // Sequencer state transitions and the retire strobe
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if ((call_c && full_c) || (ret_c && empty_c)) begin
                    state_d = ST_ERR;
                end else if (wait_req_c) begin
                    state_d = ST_WAIT;
                end else begin
                    commit_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (press_c) begin
                    commit_c = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Next PC and stack pointer; stack ops take precedence over jump/branch
    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        push_c = 1'b0;
        err_d  = err_q | (state_d == ST_ERR);
        if (commit_c) begin
            if (call_c) begin
                pc_d   = Jump_Addr;
                push_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end else if (ret_c) begin
                pc_d  = top_c;
                cnt_d = cnt_q - CNT_W'(1);
            end else if (Jump || (Branch && ALU_True)) begin
                pc_d = Jump_Addr;
            end else begin
                pc_d = pc_inc_c;
            end
        end
    end

    always_ff @(posedge Sys_Clock or negedge Reset_Raw) begin
        if (!Reset_Raw) begin
            state_q <= ST_RUN;
            pc_q    <= PC_WIDTH'(RESET_PC);
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            btn_q   <= DB_Button;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge Sys_Clock or negedge Reset_Raw) begin
        if (!Reset_Raw) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_c) begin
            stack_q[IDX_W'(cnt_q)] <= pc_inc_c;
        end
    end

    // Commit is forced low while reset is held, even though state reads RUN
    assign Commit    = commit_c & Reset_Raw;
    assign PC        = pc_q;
    assign Ret_Add   = top_c;
    assign Err_Out   = err_q;
    assign Seq_State = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected retirements queued by stimulus, checked by a monitor.
module tb_pc_sequencer;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ret;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       halt, io_wait, db_button, jump, branch, alu_true, stack_en, stack_wr;
    logic [7:0] jump_addr;
    logic [7:0] pc, ret_add;
    logic       commit, err_out;
    logic [1:0] seq_state;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    pc_sequencer dut (
        .Sys_Clock    (clk),
        .Reset_Raw    (rst_n),
        .Halt         (halt),
        .IO_Wait      (io_wait),
        .DB_Button    (db_button),
`ifdef REAPER_SINGLE_STEP_EN
        .Step_Mode    (1'b0),
`endif
        .Jump         (jump),
        .Branch       (branch),
        .ALU_True     (alu_true),
        .Stack_Enable (stack_en),
        .Stack_Write  (stack_wr),
        .Jump_Addr    (jump_addr),
        .PC           (pc),
        .Ret_Add      (ret_add),
        .Commit       (commit),
        .Err_Out      (err_out),
        .Seq_State    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic ctl(input logic h, input logic iw, input logic j, input logic b,
                       input logic a, input logic se, input logic sw, input logic [7:0] addr);
        halt = h; io_wait = iw; jump = j; branch = b;
        alu_true = a; stack_en = se; stack_wr = sw; jump_addr = addr;
    endtask

    task automatic expect_commit(input logic [7:0] p, input logic [7:0] r);
        exp_t e;
        e.pc  = p;
        e.ret = r;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retirement must match the next queued expectation
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got commit at PC %0h expected none", pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_pc", 16'(pc), 16'(mon_e.pc));
                chk("commit_ret_add", 16'(ret_add), 16'(mon_e.ret));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl(0, 0, 0, 0, 0, 0, 0, 8'h00);
        db_button = 1'b0;
        rst_n     = 1'b0;
        #3;
        chk("reset_pc", 16'(pc), 16'h0);
        chk("reset_ret_add", 16'(ret_add), 16'h0);
        chk("reset_commit", 16'(commit), 16'h0);
        chk("reset_err", 16'(err_out), 16'h0);
        chk("reset_state", 16'(seq_state), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential run through the wrap point
        for (int i = 0; i < 258; i++) begin
            expect_commit(8'(i), 8'h00);
            tick();
        end
        chk("wrap_pc", 16'(pc), 16'h2);
        chk("wrap_pending", 16'(exp_q.size()), 16'h0);
        for (int i = 2; i < 5; i++) begin
            expect_commit(8'(i), 8'h00);
            tick();
        end

        // Call then return; return carries jump/branch that must lose
        ctl(0, 0, 0, 0, 0, 1, 1, 8'h40);
        expect_commit(8'h05, 8'h00);
        tick();
        chk("call_pc", 16'(pc), 16'h40);
        chk("call_ret_add", 16'(ret_add), 16'h06);
        ctl(0, 0, 1, 1, 1, 1, 0, 8'h99);
        expect_commit(8'h40, 8'h06);
        tick();
        chk("return_pc", 16'(pc), 16'h06);
        chk("return_ret_add", 16'(ret_add), 16'h00);
        ctl(0, 0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 6; i < 10; i++) begin
            expect_commit(8'(i), 8'h00);
            tick();
        end

        // Branch not taken then taken
        ctl(0, 0, 0, 1, 0, 0, 0, 8'h03);
        expect_commit(8'h0A, 8'h00);
        tick();
        chk("branch_nt_pc", 16'(pc), 16'h0B);
        ctl(0, 0, 0, 1, 1, 0, 0, 8'h03);
        expect_commit(8'h0B, 8'h00);
        tick();
        chk("branch_t_pc", 16'(pc), 16'h03);
        ctl(0, 0, 0, 0, 0, 0, 0, 8'h00);
        db_button = 1'b1;
        for (int i = 3; i < 20; i++) begin
            expect_commit(8'(i), 8'h00);
            tick();
        end

        // IO wait entered with the button already held
        ctl(0, 1, 0, 0, 0, 0, 0, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("io_state", 16'(seq_state), 16'h1);
            chk("io_pc_held", 16'(pc), 16'd20);
            chk("io_commit", 16'(commit), 16'h0);
            tick();
        end
        db_button = 1'b0;
        tick();
        tick();
        db_button = 1'b1;
        expect_commit(8'd20, 8'h00);
        tick();
        chk("io_pc_after", 16'(pc), 16'd21);
        @(negedge clk);
        chk("io_single_commit", 16'(commit), 16'h0);
        tick();
        chk("io_rewait_state", 16'(seq_state), 16'h1);
        db_button = 1'b0;
        tick();
        db_button = 1'b1;
        io_wait   = 1'b0;
        expect_commit(8'd21, 8'h00);
        tick();
        chk("io2_pc", 16'(pc), 16'd22);
        chk("io2_state", 16'(seq_state), 16'h0);

        // Call from 0xFF pushes the wrapped address 0
        ctl(0, 0, 1, 0, 0, 0, 0, 8'hFF);
        expect_commit(8'd22, 8'h00);
        tick();
        ctl(0, 0, 0, 0, 0, 1, 1, 8'h80);
        expect_commit(8'hFF, 8'h00);
        tick();
        chk("call_ff_pc", 16'(pc), 16'h80);
        ctl(0, 0, 0, 0, 0, 1, 0, 8'h00);
        expect_commit(8'h80, 8'h00);
        tick();
        chk("ret_wrap_pc", 16'(pc), 16'h00);

        // Fill the stack, then overflow
        for (int k = 0; k < 8; k++) begin
            ctl(0, 0, 0, 0, 0, 1, 1, 8'((k + 1) * 16));
            expect_commit(8'(k * 16), (k == 0) ? 8'h00 : 8'(k * 16 - 15));
            tick();
        end
        chk("full_pc", 16'(pc), 16'h80);
        chk("full_ret_add", 16'(ret_add), 16'h71);
        ctl(0, 0, 0, 0, 0, 1, 1, 8'h90);
        tick();
        chk("ovf_err", 16'(err_out), 16'h1);
        chk("ovf_state", 16'(seq_state), 16'h3);
        chk("ovf_pc", 16'(pc), 16'h80);
        ctl(0, 0, 0, 0, 0, 0, 0, 8'h00);
        tick();
        tick();
        chk("ovf_frozen_pc", 16'(pc), 16'h80);
        chk("ovf_commit", 16'(commit), 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", 16'(pc), 16'h0);
        chk("midrst_err", 16'(err_out), 16'h0);
        chk("midrst_state", 16'(seq_state), 16'h0);
        chk("midrst_ret_add", 16'(ret_add), 16'h0);
        chk("midrst_commit", 16'(commit), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Underflow: return on an empty stack
        ctl(0, 0, 0, 0, 0, 1, 0, 8'h00);
        tick();
        chk("udf_state", 16'(seq_state), 16'h3);
        chk("udf_err", 16'(err_out), 16'h1);
        chk("udf_pc", 16'(pc), 16'h0);
        ctl(0, 0, 0, 0, 0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Halt at PC 7
        for (int i = 0; i < 7; i++) begin
            expect_commit(8'(i), 8'h00);
            tick();
        end
        ctl(1, 0, 0, 0, 0, 0, 0, 8'h00);
        tick();
        chk("halt_state", 16'(seq_state), 16'h2);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("halt_pc", 16'(pc), 16'h7);
            chk("halt_commit", 16'(commit), 16'h0);
        end
        chk("final_pending", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and return-address stack for the Reaper processor. It owns the 8-bit PC and computes the next PC from the decoded jump, branch, call and return controls. It stalls on input instructions until a debounced button press, and freezes on halt or on stack overflow/underflow. It issues a single commit strobe that the datapath uses to gate register-file, memory and stack writes.

## Interface
Parameters:
- PC_WIDTH, 8, width of PC, Jump_Addr and stack entries
- STACK_DEPTH, 8, return-address stack entries (power of two, 2..32)
- RESET_PC, 0, PC value after reset

Ports:
- Sys_Clock  in  1  system clock; all state changes on rising edge
- Reset_Raw  in  1  asynchronous, active-low reset
- Halt  in  1  current instruction is HALT
- IO_Wait  in  1  current instruction is an input instruction that waits for the button
- DB_Button  in  1  debounced button level, synchronous to Sys_Clock
- Jump  in  1  unconditional jump
- Branch  in  1  conditional branch
- ALU_True  in  1  branch condition from ALU
- Stack_Enable  in  1  stack operation this instruction
- Stack_Write  in  1  with Stack_Enable: 1 = call (push), 0 = return (pop)
- Jump_Addr  in  PC_WIDTH  jump/branch/call target
- PC  out  PC_WIDTH  current instruction address (registered)
- Ret_Add  out  PC_WIDTH  top-of-stack value; 0 when stack empty
- Commit  out  1  current instruction retires this cycle (combinational)
- Err_Out  out  1  sticky stack-error flag (registered)
- Seq_State  out  2  state encoding: 0 RUN, 1 WAIT_PRESS, 2 HALTED, 3 ERROR

## Operation
- States: RUN, WAIT_PRESS, HALTED, ERROR.
- RUN checks, in priority order:
  - Halt: go to HALTED; Commit=0; PC held.
  - Stack_Enable&Stack_Write with count==STACK_DEPTH, or Stack_Enable&!Stack_Write with count==0: go to ERROR; Commit=0; PC held.
  - IO_Wait: go to WAIT_PRESS; Commit=0; PC held.
  - Otherwise: Commit=1; next PC per the rules below.
- WAIT_PRESS:
  - Press edge: DB_Button=1 and Btn_Q=0. Btn_Q is DB_Button registered every cycle; reset value 0.
  - On a press edge: Commit=1, next PC per the rules below, return to RUN.
  - A button already held on entry must be released and pressed again.
  - Controls are held stable because the PC is frozen.
- HALTED and ERROR: PC frozen, Commit=0; exit only via reset. ERROR sets Err_Out=1.
- Next-PC rules on commit, in priority order:
  - Call: push PC+1 and take Jump_Addr.
  - Return: pop and take the top entry.
  - Jump: take Jump_Addr.
  - Branch&ALU_True: take Jump_Addr.
  - Otherwise PC+1.
- Arithmetic is modulo 2^PC_WIDTH: 255+1 = 0. A call at PC=255 pushes 0.
- Jump and Branch asserted together with a stack op: the stack op wins.
- Stack is a register array with a count of 0..STACK_DEPTH. Ret_Add = entry[count-1].

## Timing
- Reset (asynchronous assert): PC=RESET_PC, count=0, state=RUN, Err_Out=0, Btn_Q=0, Ret_Add=0, Commit=0 while reset is asserted.
- Reset release: the first rising edge after deassertion is a normal RUN cycle.
- Reset asserted mid-WAIT_PRESS or mid-HALTED returns everything to the reset values immediately.
- Single-cycle sequencing: PC updates on the rising edge of the commit cycle, so one instruction retires per cycle in RUN.
- Commit depends combinationally on state, decoded inputs, DB_Button and Btn_Q. There is no path from Commit back to the inputs.
- IO latency: minimum 1 stall cycle. The instruction retires in the cycle of the press edge.
- Stack push/pop and the PC update take effect on the same edge. Ret_Add reflects the new top the following cycle.

## Configuration
- Macro: REAPER_SINGLE_STEP_EN.
- Defined:
  - Adds input port Step_Mode (1 bit, placed after DB_Button).
  - While Step_Mode=1, RUN treats every non-halting, non-erroring instruction as if IO_Wait=1: each instruction waits in WAIT_PRESS for a press edge.
  - Step_Mode changes take effect at the next RUN cycle.
- Undefined: no Step_Mode port; behaviour as above.

## Test plan
- Sequential run: reset, no controls for 258 cycles -> Commit=1 every cycle; PC goes 0..255, 0, 1.
- Call/return: PC=5, Stack_Enable=1, Stack_Write=1, Jump_Addr=0x40 -> PC=0x40, Ret_Add=6. Then Stack_Enable=1, Stack_Write=0 -> PC=6, Ret_Add=0.
- Branch: Branch=1, ALU_True=0 at PC=10 -> PC=11. Branch=1, ALU_True=1, Jump_Addr=3 -> PC=3.
- IO wait: IO_Wait=1 at PC=20 with DB_Button already high -> Seq_State=1, PC=20 held, Commit=0. Release, then press -> Commit=1 for exactly one cycle, PC=21.
- Stack overflow: 8 calls then a 9th call -> Err_Out=1, Seq_State=3, PC frozen. Assert Reset_Raw=0 mid-cycle -> PC=0, Err_Out=0 immediately.
- Halt: Halt=1 at PC=7 -> Seq_State=2; PC stays 7 for 100 cycles; Commit=0 throughout.
